// File: rtl/reg_file_param_if.sv
// Bus bundle for the parameterised register file: one write port, two read ports, clear control.
interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] in;
  logic [ADDR_W-1:0] inaddress;
  logic              write;
  logic [ADDR_W-1:0] out1address;
  logic [ADDR_W-1:0] out2address;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              valid1;
  logic              valid2;
  logic              clear;
  logic              busy;
  logic              wr_drop;

  modport master (
    output in, inaddress, write, out1address, out2address, clear,
    input  out1, out2, valid1, valid2, busy, wr_drop
  );

  modport slave (
    input  in, inaddress, write, out1address, out2address, clear,
    output out1, out2, valid1, valid2, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_param.sv
// Register file with two combinational read ports, optional write forwarding,
// and a sequential clear sweep that locks out writes while it runs.
//
// state    | meaning
// IDLE     | normal operation, writes accepted
// CLEARING | sweeping entry[ptr] to zero each cycle, writes dropped
module reg_file_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input logic           CLK,
  input logic           RESET,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              busy;
  logic              wr_eff;
  logic              wr_drop_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      ptr       <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      wr_drop_q <= bus.write & busy;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          state_nxt = CLEARING;
          ptr_nxt   = '0;
        end
      end
      CLEARING: begin
        busy    = 1'b1;
        // natural ADDR_W wrap leaves ptr at 0 on exit
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_eff = bus.write & ~busy & ~RESET;

  // The sweep owns the storage while busy; a write accepted on the same
  // edge that CLEAR is seen still lands because state is still IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else if (busy) begin
      mem[ptr]   <= '0;
      valid[ptr] <= 1'b0;
    end else if (wr_eff) begin
      mem[bus.inaddress]   <= bus.in;
      valid[bus.inaddress] <= 1'b1;
    end
  end

  always_comb begin
    bus.out1   = mem[bus.out1address];
    bus.valid1 = valid[bus.out1address];
    bus.out2   = mem[bus.out2address];
    bus.valid2 = valid[bus.out2address];
    if (BYPASS != 0 && wr_eff && bus.out1address == bus.inaddress) begin
      bus.out1   = bus.in;
      bus.valid1 = 1'b1;
    end
    if (BYPASS != 0 && wr_eff && bus.out2address == bus.inaddress) begin
      bus.out2   = bus.in;
      bus.valid2 = 1'b1;
    end
  end

  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default, no-bypass and 16x16 instances.
module tb_reg_file_param;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a, rst_b, rst_c;
  int pass_cnt = 0;
  int total_cnt = 0;

  reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) if_a ();
  reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) if_b ();
  reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) if_c ();

  reg_file_param #(.DATA_W(8),  .ADDR_W(3), .BYPASS(1)) dut_a (.CLK(CLK), .RESET(rst_a), .bus(if_a));
  reg_file_param #(.DATA_W(8),  .ADDR_W(3), .BYPASS(0)) dut_b (.CLK(CLK), .RESET(rst_b), .bus(if_b));
  reg_file_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut_c (.CLK(CLK), .RESET(rst_c), .bus(if_c));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    total_cnt++; if (if_a.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", if_a.busy); else pass_cnt++;
    total_cnt++; if (if_a.wr_drop !== 1'b0) $display("FAIL reset wr_drop: got %b want 0", if_a.wr_drop); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if_a.out1address = 3'(i); if_a.out2address = 3'(7 - i);
      if_b.out1address = 3'(i);
      #1;
      total_cnt++; if (if_a.out1 !== 8'h00 || if_a.valid1 !== 1'b0) $display("FAIL reset a.out1[%0d]: got %h/%b want 00/0", i, if_a.out1, if_a.valid1); else pass_cnt++;
      total_cnt++; if (if_a.out2 !== 8'h00 || if_a.valid2 !== 1'b0) $display("FAIL reset a.out2[%0d]: got %h/%b want 00/0", 7 - i, if_a.out2, if_a.valid2); else pass_cnt++;
      total_cnt++; if (if_b.out1 !== 8'h00 || if_b.valid1 !== 1'b0) $display("FAIL reset b.out1[%0d]: got %h/%b want 00/0", i, if_b.out1, if_b.valid1); else pass_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      if_c.out1address = 4'(i);
      #1;
      total_cnt++; if (if_c.out1 !== 16'h0000 || if_c.valid1 !== 1'b0) $display("FAIL reset c.out1[%0d]: got %h/%b want 0000/0", i, if_c.out1, if_c.valid1); else pass_cnt++;
    end
    total_cnt++; if (if_c.busy !== 1'b0) $display("FAIL reset c.busy: got %b want 0", if_c.busy); else pass_cnt++;
  endtask

  task automatic test_write_read();
    if_a.write = 1'b1; if_a.inaddress = 3'd3; if_a.in = 8'hA5;
    if_a.out1address = 3'd0; if_a.out2address = 3'd0;
    tick();
    if_a.write = 1'b0; if_a.out1address = 3'd3; if_a.out2address = 3'd3;
    #1;
    total_cnt++; if (if_a.out1 !== 8'hA5 || if_a.valid1 !== 1'b1) $display("FAIL wr_rd out1: got %h/%b want a5/1", if_a.out1, if_a.valid1); else pass_cnt++;
    total_cnt++; if (if_a.out2 !== 8'hA5 || if_a.valid2 !== 1'b1) $display("FAIL wr_rd out2: got %h/%b want a5/1", if_a.out2, if_a.valid2); else pass_cnt++;
    total_cnt++; if (if_a.wr_drop !== 1'b0) $display("FAIL wr_rd wr_drop: got %b want 0", if_a.wr_drop); else pass_cnt++;
  endtask

  task automatic test_bypass();
    if_a.write = 1'b1; if_a.inaddress = 3'd5; if_a.in = 8'h3C;
    if_a.out1address = 3'd5; if_a.out2address = 3'd4;
    #1;
    total_cnt++; if (if_a.out1 !== 8'h3C || if_a.valid1 !== 1'b1) $display("FAIL bypass fwd: got %h/%b want 3c/1", if_a.out1, if_a.valid1); else pass_cnt++;
    total_cnt++; if (if_a.out2 !== 8'h00 || if_a.valid2 !== 1'b0) $display("FAIL bypass other port: got %h/%b want 00/0", if_a.out2, if_a.valid2); else pass_cnt++;
    tick();
    if_a.write = 1'b0;
    #1;
    total_cnt++; if (if_a.out1 !== 8'h3C) $display("FAIL bypass stored: got %h want 3c", if_a.out1); else pass_cnt++;

    if_b.write = 1'b1; if_b.inaddress = 3'd5; if_b.in = 8'h11; if_b.out1address = 3'd5;
    #1;
    total_cnt++; if (if_b.out1 !== 8'h00 || if_b.valid1 !== 1'b0) $display("FAIL nobypass first: got %h/%b want 00/0", if_b.out1, if_b.valid1); else pass_cnt++;
    tick();
    if_b.in = 8'h3C;
    #1;
    total_cnt++; if (if_b.out1 !== 8'h11 || if_b.valid1 !== 1'b1) $display("FAIL nobypass old: got %h/%b want 11/1", if_b.out1, if_b.valid1); else pass_cnt++;
    tick();
    if_b.write = 1'b0;
    #1;
    total_cnt++; if (if_b.out1 !== 8'h3C) $display("FAIL nobypass after: got %h want 3c", if_b.out1); else pass_cnt++;
  endtask

  task automatic test_clear_write_same_cycle();
    int n;
    if_a.write = 1'b1; if_a.inaddress = 3'd4; if_a.in = 8'h44; if_a.clear = 1'b1;
    if_a.out1address = 3'd4; if_a.out2address = 3'd4;
    #1;
    total_cnt++; if (if_a.out1 !== 8'h44) $display("FAIL clrwr bypass: got %h want 44", if_a.out1); else pass_cnt++;
    tick();
    if_a.write = 1'b0; if_a.clear = 1'b0;
    #1;
    total_cnt++; if (if_a.busy !== 1'b1) $display("FAIL clrwr busy: got %b want 1", if_a.busy); else pass_cnt++;
    total_cnt++; if (if_a.out1 !== 8'h44 || if_a.valid1 !== 1'b1) $display("FAIL clrwr stored: got %h/%b want 44/1", if_a.out1, if_a.valid1); else pass_cnt++;
    total_cnt++; if (if_a.wr_drop !== 1'b0) $display("FAIL clrwr wr_drop: got %b want 0", if_a.wr_drop); else pass_cnt++;
    n = 0;
    while (if_a.busy && n < 20) begin tick(); n++; end
    total_cnt++; if (if_a.busy !== 1'b0) $display("FAIL clrwr timeout: busy %b want 0", if_a.busy); else pass_cnt++;
    total_cnt++; if (if_a.out1 !== 8'h00 || if_a.valid1 !== 1'b0) $display("FAIL clrwr swept: got %h/%b want 00/0", if_a.out1, if_a.valid1); else pass_cnt++;
  endtask

  task automatic test_clear_sweep();
    for (int i = 0; i < 8; i++) begin
      if_a.write = 1'b1; if_a.inaddress = 3'(i); if_a.in = 8'(16 + i);
      tick();
    end
    if_a.write = 1'b0; if_a.clear = 1'b1;
    #1;
    total_cnt++; if (if_a.busy !== 1'b0) $display("FAIL sweep busy early: got %b want 0", if_a.busy); else pass_cnt++;
    tick();
    for (int k = 0; k < 8; k++) begin
      if_a.out1address = 3'(k); if_a.out2address = 3'(k);
      if_a.clear = (k == 3);
      #1;
      total_cnt++; if (if_a.busy !== 1'b1) $display("FAIL sweep busy[%0d]: got %b want 1", k, if_a.busy); else pass_cnt++;
      total_cnt++; if (if_a.out1 !== 8'(16 + k) || if_a.out2 !== 8'(16 + k)) $display("FAIL sweep old[%0d]: got %h/%h want %h", k, if_a.out1, if_a.out2, 8'(16 + k)); else pass_cnt++;
      tick();
      #1;
      total_cnt++; if (if_a.out1 !== 8'h00) $display("FAIL sweep zero[%0d]: got %h want 00", k, if_a.out1); else pass_cnt++;
    end
    if_a.clear = 1'b0;
    #1;
    total_cnt++; if (if_a.busy !== 1'b0) $display("FAIL sweep busy end: got %b want 0", if_a.busy); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if_a.out2address = 3'(i);
      #1;
      total_cnt++; if (if_a.out2 !== 8'h00 || if_a.valid2 !== 1'b0) $display("FAIL sweep final[%0d]: got %h/%b want 00/0", i, if_a.out2, if_a.valid2); else pass_cnt++;
    end
  endtask

  task automatic test_write_drop();
    int n;
    for (int i = 0; i < 8; i++) begin
      if_a.write = 1'b1; if_a.inaddress = 3'(i); if_a.in = 8'(32 + i);
      tick();
    end
    if_a.write = 1'b0; if_a.clear = 1'b1;
    tick();
    if_a.clear = 1'b0;
    tick(); tick();
    if_a.write = 1'b1; if_a.inaddress = 3'd2; if_a.in = 8'hFF; if_a.out1address = 3'd2;
    #1;
    total_cnt++; if (if_a.out1 !== 8'h22 || if_a.valid1 !== 1'b1) $display("FAIL drop no-bypass: got %h/%b want 22/1", if_a.out1, if_a.valid1); else pass_cnt++;
    total_cnt++; if (if_a.wr_drop !== 1'b0) $display("FAIL drop early: got %b want 0", if_a.wr_drop); else pass_cnt++;
    tick();
    if_a.write = 1'b0;
    #1;
    total_cnt++; if (if_a.wr_drop !== 1'b1) $display("FAIL drop pulse: got %b want 1", if_a.wr_drop); else pass_cnt++;
    total_cnt++; if (if_a.out1 !== 8'h00) $display("FAIL drop entry: got %h want 00", if_a.out1); else pass_cnt++;
    tick();
    total_cnt++; if (if_a.wr_drop !== 1'b0) $display("FAIL drop width: got %b want 0", if_a.wr_drop); else pass_cnt++;
    n = 0;
    while (if_a.busy && n < 20) begin tick(); n++; end
    total_cnt++; if (if_a.busy !== 1'b0) $display("FAIL drop timeout: busy %b want 0", if_a.busy); else pass_cnt++;
    total_cnt++; if (if_a.out1 !== 8'h00 || if_a.valid1 !== 1'b0) $display("FAIL drop final: got %h/%b want 00/0", if_a.out1, if_a.valid1); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 8; i++) begin
      if_a.write = 1'b1; if_a.inaddress = 3'(i); if_a.in = 8'(48 + i);
      tick();
    end
    if_a.write = 1'b0; if_a.clear = 1'b1;
    tick();
    if_a.clear = 1'b0;
    tick(); tick(); tick();
    if_a.out2address = 3'd5;
    rst_a = 1'b1; if_a.write = 1'b1; if_a.inaddress = 3'd6; if_a.in = 8'h99;
    #1;
    total_cnt++; if (if_a.out2 !== 8'h35) $display("FAIL abort unswept: got %h want 35", if_a.out2); else pass_cnt++;
    tick();
    rst_a = 1'b0; if_a.write = 1'b0;
    #1;
    total_cnt++; if (if_a.busy !== 1'b0) $display("FAIL abort busy: got %b want 0", if_a.busy); else pass_cnt++;
    total_cnt++; if (if_a.wr_drop !== 1'b0) $display("FAIL abort wr_drop: got %b want 0", if_a.wr_drop); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if_a.out1address = 3'(i);
      #1;
      total_cnt++; if (if_a.out1 !== 8'h00 || if_a.valid1 !== 1'b0) $display("FAIL abort entry[%0d]: got %h/%b want 00/0", i, if_a.out1, if_a.valid1); else pass_cnt++;
    end
    if_a.write = 1'b1; if_a.inaddress = 3'd7; if_a.in = 8'h5A;
    tick();
    if_a.write = 1'b0; if_a.out1address = 3'd7;
    #1;
    total_cnt++; if (if_a.out1 !== 8'h5A || if_a.valid1 !== 1'b1) $display("FAIL abort rewrite: got %h/%b want 5a/1", if_a.out1, if_a.valid1); else pass_cnt++;
  endtask

  task automatic test_wide();
    int n;
    if_c.write = 1'b1; if_c.inaddress = 4'd15; if_c.in = 16'hBEEF;
    tick();
    if_c.write = 1'b0; if_c.out1address = 4'd15;
    #1;
    total_cnt++; if (if_c.out1 !== 16'hBEEF || if_c.valid1 !== 1'b1) $display("FAIL wide write: got %h/%b want beef/1", if_c.out1, if_c.valid1); else pass_cnt++;
    if_c.clear = 1'b1;
    tick();
    if_c.clear = 1'b0;
    n = 0;
    while (if_c.busy && n < 40) begin n++; tick(); end
    total_cnt++; if (n !== 16) $display("FAIL wide busy cycles: got %0d want 16", n); else pass_cnt++;
    total_cnt++; if (if_c.out1 !== 16'h0000 || if_c.valid1 !== 1'b0) $display("FAIL wide swept: got %h/%b want 0000/0", if_c.out1, if_c.valid1); else pass_cnt++;
    if_c.write = 1'b1; if_c.inaddress = 4'd0; if_c.in = 16'h1234;
    tick();
    if_c.write = 1'b0; if_c.out1address = 4'd0;
    #1;
    total_cnt++; if (if_c.out1 !== 16'h1234 || if_c.busy !== 1'b0) $display("FAIL wide after wrap: got %h/%b want 1234/0", if_c.out1, if_c.busy); else pass_cnt++;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.in = '0; if_a.inaddress = '0; if_a.write = 1'b0; if_a.clear = 1'b0;
    if_a.out1address = '0; if_a.out2address = '0;
    if_b.in = '0; if_b.inaddress = '0; if_b.write = 1'b0; if_b.clear = 1'b0;
    if_b.out1address = '0; if_b.out2address = '0;
    if_c.in = '0; if_c.inaddress = '0; if_c.write = 1'b0; if_c.clear = 1'b0;
    if_c.out1address = '0; if_c.out2address = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_write_same_cycle();
    test_clear_sweep();
    test_write_drop();
    test_reset_abort();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries (legal range 1..8).
REQ-003 The block SHALL have parameter BYPASS, default 1, read-during-write forwarding enable (0 = off, 1 = on).
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESET  input  1  reset, synchronous, active-high.
REQ-006 IN  input  DATA_W  write data.
REQ-007 INADDRESS  input  ADDR_W  write address.
REQ-008 WRITE  input  1  write request, sampled at rising CLK.
REQ-009 OUT1ADDRESS, OUT2ADDRESS  input  ADDR_W each  read port addresses.
REQ-010 OUT1, OUT2  output  DATA_W each  read data.
REQ-011 VALID1, VALID2  output  1 each  addressed entry written since last reset/clear.
REQ-012 CLEAR  input  1  request sequential clear of the whole file.
REQ-013 BUSY  output  1  high while a clear sequence is in progress.
REQ-014 WR_DROP  output  1  registered one-cycle pulse: a write was rejected.

Function
REQ-015 Storage SHALL be DEPTH x DATA_W registers plus one valid bit per entry.
REQ-016 Reads SHALL be combinational, with zero latency: OUTn = entry[OUTnADDRESS], VALIDn = valid[OUTnADDRESS].
REQ-017 The block SHALL perform an effective write (WRITE=1, BUSY=0, RESET=0) at the rising edge: entry[INADDRESS] <= IN, valid[INADDRESS] <= 1.
REQ-018 With BYPASS=1, during an effective write where OUTnADDRESS==INADDRESS, the block SHALL drive OUTn = IN and VALIDn = 1 in the same cycle.
REQ-019 With BYPASS=0, OUTn SHALL show the old contents until the edge after the write.
REQ-020 The block SHALL support both read ports addressing the same entry simultaneously, with identical results on each port.
REQ-021 The FSM SHALL have two states: IDLE and CLEARING; BUSY = (state == CLEARING).
REQ-022 In IDLE, CLEAR=1 at the rising edge SHALL move the FSM to CLEARING and load the clear pointer with 0.
REQ-023 A write presented in the same cycle as CLEAR in IDLE SHALL be performed (BUSY is still 0), and the sweep SHALL later zero that entry.
REQ-024 In CLEARING, each edge SHALL set entry[ptr] <= 0 and valid[ptr] <= 0, and ptr <= ptr+1.
REQ-025 The FSM SHALL return to IDLE on the edge that clears entry DEPTH-1, so BUSY is high for exactly DEPTH cycles.
REQ-026 The pointer SHALL be ADDR_W bits wide and wrap to 0 on exit; there SHALL be no out-of-range access.
REQ-027 CLEAR asserted while in CLEARING SHALL be ignored and SHALL NOT restart or extend the sweep.
REQ-028 WRITE=1 while BUSY=1 SHALL be discarded, with no storage change and no bypass, and SHALL set WR_DROP=1 for the next cycle only.
REQ-029 Reads during CLEARING SHALL return current contents: 0 for swept entries, old data for entries not yet swept.
REQ-030 WR_DROP SHALL be 0 in every cycle not covered by REQ-028.

Reset
REQ-031 RESET=1 at a rising edge SHALL zero all entries and valid bits, set state to IDLE, ptr to 0, BUSY to 0 and WR_DROP to 0, all in that single edge.
REQ-032 RESET SHALL take priority over WRITE and CLEAR in the same cycle and SHALL abort a clear sequence in progress.
REQ-033 After reset, OUT1/OUT2 SHALL read 0 and VALID1/VALID2 SHALL read 0 for every address.

Verification
REQ-034 Defaults, write 8'hA5 to addr 3 then read on both ports with addr 3 -> OUT1 = OUT2 = 8'hA5, VALID1 = VALID2 = 1 on the next cycle.
REQ-035 BYPASS=1, WRITE addr 5 = 8'h3C with OUT1ADDRESS = 5 in the same cycle -> OUT1 = 8'h3C before the edge; with BYPASS=0 -> old value until after the edge.
REQ-036 Fill all 8 entries, pulse CLEAR -> BUSY high for exactly 8 cycles, entries read 0 in order 0..7, all VALID = 0 after the sweep.
REQ-037 WRITE addr 2 = 8'hFF during cycle 3 of the sweep -> entry 2 stays 0 and WR_DROP pulses for one cycle.
REQ-038 RESET during cycle 4 of the sweep -> next cycle BUSY = 0, all entries 0; a following write to addr 7 succeeds.
REQ-039 DATA_W=16, ADDR_W=4 -> write 16'hBEEF to addr 15, BUSY lasts 16 cycles on clear, and the pointer wraps without error.
